// File: rtl/cmd_deframer.sv
// rtl/cmd_deframer.sv - byte-serial command frame receiver and field decomposer
module cmd_deframer #(
    parameter int          N_FIELDS    = 6,
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter int          TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [8*N_FIELDS-1:0] fields,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_V = TW'(TIMEOUT);
    localparam logic [4:0] LAST_IDX = 5'(N_FIELDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIELDS = 2'd1,
        SUM    = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [8*N_FIELDS-1:0]   shadow, shadow_next;
    logic [7:0]              run_sum;
    logic [4:0]              idx;
    logic [TW-1:0]           idle_cnt;
    logic                    start, take, commit, sum_err, tmo;

    // State register; a low enable forces the hunt state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (!in)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and per-cycle control decode; timeout wins over a byte arriving the same cycle
    always_comb begin
        state_next = state;
        start      = 1'b0;
        take       = 1'b0;
        commit     = 1'b0;
        sum_err    = 1'b0;
        tmo        = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    start      = 1'b1;
                    state_next = FIELDS;
                end
            end
            FIELDS: begin
                if (idle_cnt == TMO_V) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    take = 1'b1;
                    if (idx == LAST_IDX) begin
                        if (CHECKSUM_EN) begin
                            state_next = SUM;
                        end else begin
                            commit     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            SUM: begin
                if (idle_cnt == TMO_V) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    if (rx_data == run_sum)
                        commit = 1'b1;
                    else
                        sum_err = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow image including the byte being stored this cycle, so a no-checksum commit sees the last field
    always_comb begin
        shadow_next = shadow;
        if (take)
            shadow_next[8*(int'(LAST_IDX) - int'(idx)) +: 8] = rx_data;
    end

    // Datapath: byte capture, running sum, idle counter, committed fields and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            run_sum     <= '0;
            idx         <= '0;
            idle_cnt    <= '0;
            fields      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            busy        <= 1'b0;
        end else if (!in) begin
            shadow      <= '0;
            run_sum     <= '0;
            idx         <= '0;
            idle_cnt    <= '0;
            fields      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            busy        <= 1'b0;
        end else begin
            frame_valid <= commit;
            frame_err   <= sum_err | tmo;
            busy        <= (state_next != IDLE);
            if (sum_err)
                err_code <= 2'b01;
            else if (tmo)
                err_code <= 2'b10;
            if (commit)
                fields <= shadow_next;
            if (start) begin
                run_sum  <= '0;
                idx      <= '0;
                idle_cnt <= '0;
            end else if (take) begin
                shadow   <= shadow_next;
                run_sum  <= run_sum + rx_data;
                idx      <= idx + 5'd1;
                idle_cnt <= '0;
            end else if (state != IDLE && !rx_valid) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmd_deframer.sv
// tb/tb_cmd_deframer.sv - directed self-checking bench for cmd_deframer
module tb_cmd_deframer;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        rxv_a, rxv_b;
    logic [7:0]  rxd_a, rxd_b;
    logic [47:0] fields_a;
    logic [15:0] fields_b;
    logic        fv_a, fe_a, busy_a, fv_b, fe_b, busy_b;
    logic [1:0]  ec_a, ec_b;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    cmd_deframer dut_a (
        .clk(clk), .rst(rst), .in(en), .rx_valid(rxv_a), .rx_data(rxd_a),
        .fields(fields_a), .frame_valid(fv_a), .frame_err(fe_a),
        .err_code(ec_a), .busy(busy_a)
    );

    cmd_deframer #(.N_FIELDS(2), .HEADER(8'hAA), .CHECKSUM_EN(1'b0), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .in(en), .rx_valid(rxv_b), .rx_data(rxd_b),
        .fields(fields_b), .frame_valid(fv_b), .frame_err(fe_b),
        .err_code(ec_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        rxv_a = 1'b1;
        rxd_a = b;
        tick();
        rxv_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rxv_b = 1'b1;
        rxd_b = b;
        tick();
        rxv_b = 1'b0;
    endtask

    task automatic good_frame_a();
        send_a(8'hAA); send_a(8'h01); send_a(8'h02); send_a(8'h03);
        send_a(8'h04); send_a(8'h05); send_a(8'h06); send_a(8'h15);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        rxv_a = 1'b0; rxd_a = 8'h00; rxv_b = 1'b0; rxd_b = 8'h00;
        #12;
        chk("reset_fields", 64'(fields_a), 64'h0);
        chk("reset_fv",     64'(fv_a),     64'h0);
        chk("reset_fe",     64'(fe_a),     64'h0);
        chk("reset_ec",     64'(ec_a),     64'h0);
        chk("reset_busy",   64'(busy_a),   64'h0);
        rst = 1'b0;
        tick();

        // good frame
        good_frame_a();
        chk("good_fv",     64'(fv_a),     64'h1);
        chk("good_fe",     64'(fe_a),     64'h0);
        chk("good_fields", 64'(fields_a), 64'h010203040506);
        tick();
        chk("good_fv_pulse", 64'(fv_a),   64'h0);
        chk("good_busy_end", 64'(busy_a), 64'h0);

        // bad checksum
        send_a(8'hAA); send_a(8'h01); send_a(8'h02); send_a(8'h03);
        send_a(8'h04); send_a(8'h05); send_a(8'h06);
        chk("bad_busy_in_sum", 64'(busy_a), 64'h1);
        send_a(8'h16);
        chk("bad_fe",     64'(fe_a),     64'h1);
        chk("bad_ec",     64'(ec_a),     64'h1);
        chk("bad_fv",     64'(fv_a),     64'h0);
        chk("bad_fields", 64'(fields_a), 64'h010203040506);
        tick();
        chk("bad_fe_pulse", 64'(fe_a), 64'h0);

        // timeout: error appears TIMEOUT+1 clocks after the last byte
        send_a(8'hAA); send_a(8'h11); send_a(8'h22);
        chk("tmo_busy", 64'(busy_a), 64'h1);
        for (int i = 0; i < 16; i++) tick();
        chk("tmo_not_early", 64'(fe_a),   64'h0);
        chk("tmo_busy_hold", 64'(busy_a), 64'h1);
        tick();
        chk("tmo_fe",     64'(fe_a),     64'h1);
        chk("tmo_ec",     64'(ec_a),     64'h2);
        chk("tmo_busy0",  64'(busy_a),   64'h0);
        chk("tmo_fields", 64'(fields_a), 64'h010203040506);
        tick();
        good_frame_a();
        chk("post_tmo_fv",     64'(fv_a),     64'h1);
        chk("post_tmo_fields", 64'(fields_a), 64'h010203040506);

        // header inside payload, then back-to-back frame
        send_a(8'hAA); send_a(8'hAA); send_a(8'h00); send_a(8'h00);
        send_a(8'h00); send_a(8'h00); send_a(8'h00); send_a(8'hAA);
        chk("hdr_fv",     64'(fv_a),     64'h1);
        chk("hdr_fields", 64'(fields_a), 64'hAA0000000000);
        good_frame_a();
        chk("b2b_fv",     64'(fv_a),     64'h1);
        chk("b2b_fields", 64'(fields_a), 64'h010203040506);
        chk("ec_held",    64'(ec_a),     64'h2);

        // small instance, no checksum, leading garbage
        send_b(8'h55);
        chk("b_garbage_busy", 64'(busy_b), 64'h0);
        send_b(8'hAA);
        send_b(8'h12);
        chk("b_mid_fv", 64'(fv_b), 64'h0);
        send_b(8'h34);
        chk("b_fv",     64'(fv_b),     64'h1);
        chk("b_fields", 64'(fields_b), 64'h1234);
        chk("b_fe",     64'(fe_b),     64'h0);

        // clear mid-frame
        send_a(8'hAA); send_a(8'h01); send_a(8'h02);
        en = 1'b0;
        tick();
        chk("clr_fields", 64'(fields_a), 64'h0);
        chk("clr_ec",     64'(ec_a),     64'h0);
        chk("clr_busy",   64'(busy_a),   64'h0);
        chk("clr_b_fields", 64'(fields_b), 64'h0);
        en = 1'b1;
        send_a(8'h03); send_a(8'h04); send_a(8'h05); send_a(8'h06); send_a(8'h15);
        chk("clr_no_fv",   64'(fv_a),   64'h0);
        chk("clr_no_busy", 64'(busy_a), 64'h0);

        // asynchronous reset mid-frame
        good_frame_a();
        send_a(8'hAA); send_a(8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fields", 64'(fields_a), 64'h0);
        chk("arst_busy",   64'(busy_a),   64'h0);
        chk("arst_fv",     64'(fv_a),     64'h0);
        rst = 1'b0;
        tick();
        send_a(8'h02); send_a(8'h03); send_a(8'h04); send_a(8'h05);
        send_a(8'h06); send_a(8'h15);
        chk("arst_no_fv", 64'(fv_a), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
